tamagotchi_action_encoder: RTL and testbench

Input-side front end for the pet core: turns raw push-button levels on the dedicated inputs into clean, one-shot care-action commands and delivers them to the stats block over a valid/ready handshake. It is the producer for the `stats` consumer. Care actions now enter as discrete, debounced events rather than as raw switch levels.

---
 rtl/tamagotchi_action_encoder.sv | 127 ++++++++++++
 tb/tb_tamagotchi_action_encoder.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/tamagotchi_action_encoder.sv
// rtl/tamagotchi_action_encoder.sv - debounced push-button to care-action command producer
module tamagotchi_action_encoder #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] buttons,
  input  logic       action_ready,
  output logic       action_valid,
  output logic [2:0] action_code,
  output logic [5:0] pressed,
  output logic [3:0] drop_count
);

  localparam int NUM_BUTTONS = 6;

  logic [NUM_BUTTONS-1:0] sync1;
  logic [NUM_BUTTONS-1:0] sync2;
  logic [NUM_BUTTONS-1:0] deb;
  logic [NUM_BUTTONS-1:0] deb_prev;
  logic [NUM_BUTTONS-1:0] rise;
  logic [NUM_BUTTONS-1:0] pending;
  logic [NUM_BUTTONS-1:0] pending_next;
  logic [NUM_BUTTONS-1:0] clr;
  logic [NUM_BUTTONS-1:0] drop_vec;
  logic                   load;
  logic                   sel_hit;
  logic [2:0]             sel_idx;
  logic [2:0]             drop_num;
  logic [4:0]             drop_sum;
  logic                   unused_buttons;

  assign unused_buttons = ^buttons[7:6];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= buttons[NUM_BUTTONS-1:0];
      sync2 <= sync1;
    end
  end

  // The debounced level only follows the synchronized level after it has
  // differed for DEBOUNCE_CYCLES consecutive cycles.
  for (genvar g = 0; g < NUM_BUTTONS; g++) begin : g_btn
    logic [15:0] cnt;
    logic        level;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cnt   <= '0;
        level <= 1'b0;
      end else if (sync2[g] != level) begin
        if (cnt == DEBOUNCE_CYCLES - 16'd1) begin
          level <= sync2[g];
          cnt   <= '0;
        end else begin
          cnt <= cnt + 16'd1;
        end
      end else begin
        cnt <= '0;
      end
    end

    assign deb[g] = level;
  end

  assign pressed = deb;
  assign rise    = deb & ~deb_prev;
  assign load    = !action_valid || action_ready;

  always_comb begin
    sel_hit = 1'b0;
    sel_idx = 3'd0;
    for (int i = NUM_BUTTONS - 1; i >= 0; i--) begin
      if (pending[i]) begin
        sel_hit = 1'b1;
        sel_idx = 3'(i);
      end
    end
  end

  always_comb begin
    clr = '0;
    if (load && sel_hit) begin
      clr[sel_idx] = 1'b1;
    end
  end

  // A new press on a button whose command is still waiting is lost; a press
  // coinciding with its own clear is kept because set wins.
  assign drop_vec     = rise & pending & ~clr;
  assign pending_next = (pending & ~clr) | rise;

  always_comb begin
    drop_num = 3'd0;
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      drop_num = drop_num + {2'b00, drop_vec[i]};
    end
    drop_sum = {1'b0, drop_count} + {2'b00, drop_num};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      deb_prev   <= '0;
      pending    <= '0;
      drop_count <= '0;
    end else begin
      deb_prev   <= deb;
      pending    <= pending_next;
      drop_count <= (drop_sum > 5'd15) ? 4'd15 : drop_sum[3:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      action_valid <= 1'b0;
      action_code  <= 3'd0;
    end else if (load) begin
      action_valid <= sel_hit;
      action_code  <= sel_hit ? (sel_idx + 3'd1) : 3'd0;
    end
  end

endmodule

// File: tb/tb_tamagotchi_action_encoder.sv
// tb/tb_tamagotchi_action_encoder.sv - table plus scoreboard bench for tamagotchi_action_encoder
module tb_tamagotchi_action_encoder;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] buttons = 8'h00;
  logic       action_ready = 1'b1;
  logic       action_valid;
  logic [2:0] action_code;
  logic [5:0] pressed;
  logic [3:0] drop_count;

  int vectors = 0;
  int miscompares = 0;
  int hs_count = 0;
  logic [2:0] exp_q[$];

  typedef struct {
    logic [7:0] btn;
    logic [5:0] exp_pressed;
  } vec_t;

  vec_t vecs[5];

  tamagotchi_action_encoder #(.DEBOUNCE_CYCLES(16'd4)) dut (
    .clk(clk),
    .reset(reset),
    .buttons(buttons),
    .action_ready(action_ready),
    .action_valid(action_valid),
    .action_code(action_code),
    .pressed(pressed),
    .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every accepted command must match the oldest expected code.
  always @(negedge clk) begin
    if (!reset) begin
      if (!action_valid) begin
        if (action_code !== 3'd0) check("idle_code_zero", {29'd0, action_code}, 32'd0);
      end else if (action_ready) begin
        hs_count++;
        if (exp_q.size() == 0) begin
          check("unexpected_command", {29'd0, action_code}, 32'd0);
        end else begin
          check("accepted_code", {29'd0, action_code}, {29'd0, exp_q.pop_front()});
        end
      end
    end
  end

  task automatic press(input int idx);
    buttons[idx] = 1'b1;
    repeat (12) @(negedge clk);
    buttons[idx] = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: timeout reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1);
  end

  initial begin
    int hs0;
    logic ok;

    vecs[0] = '{btn: 8'h01, exp_pressed: 6'h01};
    vecs[1] = '{btn: 8'h32, exp_pressed: 6'h32};
    vecs[2] = '{btn: 8'hC0, exp_pressed: 6'h00};
    vecs[3] = '{btn: 8'h3F, exp_pressed: 6'h3F};
    vecs[4] = '{btn: 8'h4C, exp_pressed: 6'h0C};

    repeat (3) @(negedge clk);
    check("reset_valid", {31'd0, action_valid}, 32'd0);
    check("reset_code", {29'd0, action_code}, 32'd0);
    check("reset_pressed", {26'd0, pressed}, 32'd0);
    check("reset_drop", {28'd0, drop_count}, 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Latency of a clean feed press with N=4.
    action_ready = 1'b1;
    exp_q.push_back(3'd1);
    buttons[0] = 1'b1;
    @(posedge clk);
    repeat (4) @(posedge clk);
    #1 check("lat_pressed_E4", {26'd0, pressed}, 32'd0);
    @(posedge clk);
    #1 check("lat_pressed_E5", {26'd0, pressed}, 32'h01);
    @(posedge clk);
    #1 check("lat_valid_E6", {31'd0, action_valid}, 32'd0);
    @(posedge clk);
    #1 check("lat_valid_E7", {31'd0, action_valid}, 32'd1);
    check("lat_code_E7", {29'd0, action_code}, 32'd1);
    @(posedge clk);
    #1 check("lat_valid_E8", {31'd0, action_valid}, 32'd0);
    hs0 = hs_count;
    repeat (100) @(negedge clk);
    check("hold_no_repeat", hs_count - hs0, 32'd0);
    buttons[0] = 1'b0;
    repeat (12) @(negedge clk);

    // Table-driven simultaneous presses; expected codes come in ascending index order.
    for (int v = 0; v < 5; v++) begin
      for (int i = 0; i < 6; i++) if (vecs[v].btn[i]) exp_q.push_back(3'(i + 1));
      buttons = vecs[v].btn;
      repeat (12) @(negedge clk);
      check("vec_pressed", {26'd0, pressed}, {26'd0, vecs[v].exp_pressed});
      buttons = 8'h00;
      repeat (12) @(negedge clk);
      check("vec_released", {26'd0, pressed}, 32'd0);
      check("vec_drained", exp_q.size(), 32'd0);
      check("vec_drop", {28'd0, drop_count}, 32'd0);
    end

    // Three-cycle glitch on clean must never be seen.
    ok = 1'b1;
    buttons[3] = 1'b1;
    repeat (3) @(negedge clk);
    buttons[3] = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (pressed != 6'd0 || action_valid) ok = 1'b0;
    end
    check("glitch_ignored", {31'd0, ok}, 32'd1);
    check("glitch_drop", {28'd0, drop_count}, 32'd0);

    // Backpressure: feed held in the output, play waits, then both drain back to back.
    action_ready = 1'b0;
    exp_q.push_back(3'd1);
    exp_q.push_back(3'd2);
    press(0);
    check("bp_valid", {31'd0, action_valid}, 32'd1);
    check("bp_code1", {29'd0, action_code}, 32'd1);
    press(1);
    check("bp_code_held", {29'd0, action_code}, 32'd1);
    action_ready = 1'b1;
    @(posedge clk);
    #1 check("bp_next_valid", {31'd0, action_valid}, 32'd1);
    check("bp_next_code", {29'd0, action_code}, 32'd2);
    @(posedge clk);
    #1 check("bp_empty", {31'd0, action_valid}, 32'd0);
    repeat (3) @(negedge clk);
    check("bp_drained", exp_q.size(), 32'd0);

    // Drops: first press presented, second pending, later presses lost.
    action_ready = 1'b0;
    exp_q.push_back(3'd1);
    exp_q.push_back(3'd1);
    press(0);
    press(0);
    check("drop_none_yet", {28'd0, drop_count}, 32'd0);
    press(0);
    check("drop_one", {28'd0, drop_count}, 32'd1);
    for (int k = 0; k < 20; k++) press(0);
    check("drop_saturate", {28'd0, drop_count}, 32'd15);
    action_ready = 1'b1;
    repeat (4) @(negedge clk);
    check("drop_drained", exp_q.size(), 32'd0);

    // Reset in the middle of a stalled handshake discards everything.
    action_ready = 1'b0;
    buttons[2] = 1'b1;
    repeat (12) @(negedge clk);
    check("rst_pre_valid", {31'd0, action_valid}, 32'd1);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("rst_valid", {31'd0, action_valid}, 32'd0);
    check("rst_code", {29'd0, action_code}, 32'd0);
    check("rst_pressed", {26'd0, pressed}, 32'd0);
    check("rst_drop", {28'd0, drop_count}, 32'd0);
    buttons[2] = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    action_ready = 1'b1;
    hs0 = hs_count;
    repeat (20) @(negedge clk);
    check("rst_no_stale", hs_count - hs0, 32'd0);
    check("final_queue_empty", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
